spart_bus_ctrl: RTL and testbench

SPART_BUS_CTRL -- requirements
Module: spart_bus_ctrl

---
 rtl/spart_bus_ctrl.sv | 126 ++++++++++++
 tb/tb_spart_bus_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/spart_bus_ctrl.sv
// spart_bus_ctrl: SPART processor bus interface with a programmable baud generator,
// a single-byte transmit holding register and a receive buffer with sticky error flags.
module spart_bus_ctrl #(
   parameter logic [15:0] DEFAULT_DIV = 16'd325,
   parameter int          OVERSAMPLE  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   input  logic       tbr_in,
   input  logic       rda_in,
   input  logic [7:0] rx_data,
   output logic [7:0] tx_data,
   output logic       tx_load,
   output logic       rx_ack,
   output logic       rx_en,
   output logic       tx_en
);
   typedef enum logic {CFG_IDLE, LO_STAGED} cfg_t;
   typedef enum logic {TX_EMPTY, TX_PEND} tx_t;
   localparam logic [3:0] SUB_TOP = 4'(OVERSAMPLE - 1);
   cfg_t        cfg_q, cfg_d;
   tx_t         tx_q, tx_d;
   logic [15:0] div_q, div_d, cnt_q, cnt_d;
   logic [7:0]  lo_q, lo_d, tx_data_q, tx_data_d, rx_buf_q, rx_buf_d;
   logic [3:0]  sub_q, sub_d;
   logic        rx_en_q, rx_en_d, tx_en_q, tx_en_d;
   logic        rx_full_q, rx_full_d, overrun_q, overrun_d, tx_drop_q, tx_drop_d, rda_q;
   logic        wr, rd, wr_dat, wr_lo, wr_hi, rd_dat, rd_stat, tick, rise, drop_set;
   logic [7:0]  status;
   assign wr      = iocs & ~iorw;
   assign rd      = iocs & iorw;
   assign wr_dat  = wr && ioaddr == 2'b00;
   assign wr_lo   = wr && ioaddr == 2'b10;
   assign wr_hi   = wr && ioaddr == 2'b11;
   assign rd_dat  = rd && ioaddr == 2'b00;
   assign rd_stat = rd && ioaddr == 2'b01;
   assign tick    = div_q != 16'd0 && cnt_q == 16'd0;
   assign rise    = rda_in & ~rda_q;
   assign status  = {4'b0, overrun_q, tx_drop_q, tx_q == TX_EMPTY, rx_full_q};
   assign tx_load = tx_q == TX_PEND && tx_en_q && tbr_in;
   assign rx_ack  = rd_dat;
   assign rx_en   = rx_en_q;
   assign tx_en   = tx_en_q;
   assign tx_data = tx_data_q;
   assign dout    = !rd ? 8'h00 : ioaddr == 2'b00 ? rx_buf_q : ioaddr == 2'b01 ? status :
                    ioaddr == 2'b10 ? div_q[7:0] : div_q[15:8];
   // Divisor commit restarts the baud phase; a zero divisor freezes the generator.
   always_comb begin
      cfg_d   = cfg_q;
      lo_d    = lo_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      sub_d   = sub_q;
      rx_en_d = 1'b0;
      tx_en_d = 1'b0;
      if (wr_lo) begin
         lo_d  = din;
         cfg_d = LO_STAGED;
      end
      if (wr_hi) begin
         div_d = {din, cfg_q == LO_STAGED ? lo_q : div_q[7:0]};
         cnt_d = div_d - 16'd1;
         sub_d = 4'd0;
         cfg_d = CFG_IDLE;
      end else if (div_q != 16'd0) begin
         cnt_d   = cnt_q == 16'd0 ? div_q - 16'd1 : cnt_q - 16'd1;
         sub_d   = !tick ? sub_q : sub_q == SUB_TOP ? 4'd0 : sub_q + 4'd1;
         rx_en_d = tick;
         tx_en_d = tick && sub_q == SUB_TOP;
      end
   end
   // A write landing in the load cycle refills the holding register instead of dropping.
   always_comb begin
      tx_d      = tx_q;
      tx_data_d = tx_data_q;
      drop_set  = 1'b0;
      if (tx_q == TX_EMPTY || tx_load) begin
         tx_d      = wr_dat ? TX_PEND : TX_EMPTY;
         tx_data_d = wr_dat ? din : tx_data_q;
      end else begin
         drop_set = wr_dat;
      end
      rx_buf_d  = rise ? rx_data : rx_buf_q;
      rx_full_d = rise | (rx_full_q & ~rd_dat);
      overrun_d = (rise & rx_full_q & ~rd_dat) | (overrun_q & ~rd_stat);
      tx_drop_d = drop_set | (tx_drop_q & ~rd_stat);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_q     <= CFG_IDLE;
         tx_q      <= TX_EMPTY;
         div_q     <= DEFAULT_DIV;
         cnt_q     <= DEFAULT_DIV - 16'd1;
         lo_q      <= DEFAULT_DIV[7:0];
         sub_q     <= 4'd0;
         rx_en_q   <= 1'b0;
         tx_en_q   <= 1'b0;
         tx_data_q <= 8'h00;
         rx_buf_q  <= 8'h00;
         rx_full_q <= 1'b0;
         overrun_q <= 1'b0;
         tx_drop_q <= 1'b0;
         rda_q     <= 1'b0;
      end else begin
         cfg_q     <= cfg_d;
         tx_q      <= tx_d;
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         lo_q      <= lo_d;
         sub_q     <= sub_d;
         rx_en_q   <= rx_en_d;
         tx_en_q   <= tx_en_d;
         tx_data_q <= tx_data_d;
         rx_buf_q  <= rx_buf_d;
         rx_full_q <= rx_full_d;
         overrun_q <= overrun_d;
         tx_drop_q <= tx_drop_d;
         rda_q     <= rda_in;
      end
   end
endmodule

// File: tb/tb_spart_bus_ctrl.sv
// tb_spart_bus_ctrl: directed checks of bus access, baud generation, transmit and receive paths.
module tb_spart_bus_ctrl;
   logic       clk = 1'b0, rst = 1'b0, iocs = 1'b0, iorw = 1'b0, tbr_in = 1'b0, rda_in = 1'b0;
   logic [1:0] ioaddr = 2'b00;
   logic [7:0] din = 8'h00, rx_data = 8'h00;
   logic [7:0] dout, tx_data;
   logic       tx_load, rx_ack, rx_en, tx_en;
   int         errors = 0, checks = 0;
   spart_bus_ctrl dut (
      .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .din(din), .dout(dout),
      .tbr_in(tbr_in), .rda_in(rda_in), .rx_data(rx_data), .tx_data(tx_data), .tx_load(tx_load),
      .rx_ack(rx_ack), .rx_en(rx_en), .tx_en(tx_en)
   );
   always #5 clk = ~clk;
   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      iocs = 1'b1; iorw = 1'b0; ioaddr = a; din = d;
      @(negedge clk);
      iocs = 1'b0;
   endtask
   task automatic rd(input logic [1:0] a, output logic [7:0] d, output logic ack);
      @(negedge clk);
      iocs = 1'b1; iorw = 1'b1; ioaddr = a;
      #1;
      d = dout; ack = rx_ack;
      @(negedge clk);
      iocs = 1'b0;
   endtask
   task automatic test_reset();
      #12;
      iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b10;
      #1 checks++;
      if (dout !== 8'h45) begin errors++; $display("FAIL reset_div_lo got=%h exp=45", dout); end
      ioaddr = 2'b11;
      #1 checks++;
      if (dout !== 8'h01) begin errors++; $display("FAIL reset_div_hi got=%h exp=01", dout); end
      ioaddr = 2'b01;
      #1 checks++;
      if (dout !== 8'h02) begin errors++; $display("FAIL reset_status got=%h exp=02", dout); end
      checks++;
      if ({tx_data, rx_en, tx_en, tx_load} !== 11'h0) begin
         errors++; $display("FAIL reset_outs got=%h/%b%b%b exp=00/000", tx_data, rx_en, tx_en, tx_load);
      end
      iocs = 1'b0;
      @(negedge clk) rst = 1'b1;
   endtask
   task automatic test_baud();
      wr(2'b10, 8'h04);
      wr(2'b11, 8'h00);
      for (int k = 1; k <= 130; k++) begin
         checks++;
         if ({rx_en, tx_en} !== {k > 1 && k % 4 == 1, k > 1 && k % 64 == 1}) begin
            errors++;
            $display("FAIL baud_k%0d got=%b%b exp=%b%b", k, rx_en, tx_en, k > 1 && k % 4 == 1, k > 1 && k % 64 == 1);
         end
         @(negedge clk);
      end
   endtask
   task automatic test_tx();
      logic [7:0] d;
      logic       a;
      int         loads = 0, first_en = -1, load_at = -2;
      tbr_in = 1'b1;
      wr(2'b00, 8'hA5);
      for (int k = 0; k < 80; k++) begin
         if (tx_en && first_en < 0) first_en = k;
         if (tx_load) begin
            loads++; load_at = k;
            checks++;
            if (tx_data !== 8'hA5) begin errors++; $display("FAIL tx_data got=%h exp=a5", tx_data); end
         end
         @(negedge clk);
      end
      checks++;
      if (loads != 1) begin errors++; $display("FAIL tx_load_count got=%0d exp=1", loads); end
      checks++;
      if (load_at != first_en) begin errors++; $display("FAIL tx_load_cycle got=%0d exp=%0d", load_at, first_en); end
      rd(2'b01, d, a);
      checks++;
      if (d !== 8'h02) begin errors++; $display("FAIL tx_status got=%h exp=02", d); end
   endtask
   task automatic test_drop();
      logic [7:0] d;
      logic       a;
      tbr_in = 1'b0;
      wr(2'b00, 8'h11);
      wr(2'b00, 8'h22);
      checks++;
      if (tx_data !== 8'h11) begin errors++; $display("FAIL drop_data got=%h exp=11", tx_data); end
      rd(2'b01, d, a);
      checks++;
      if (d !== 8'h04) begin errors++; $display("FAIL drop_status1 got=%h exp=04", d); end
      rd(2'b01, d, a);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL drop_status2 got=%h exp=00", d); end
   endtask
   task automatic test_rx();
      logic [7:0] d;
      logic       a;
      rx_data = 8'h3C;
      @(negedge clk) rda_in = 1'b1;
      @(negedge clk) begin rda_in = 1'b0; rx_data = 8'h5A; end
      @(negedge clk) rda_in = 1'b1;
      @(negedge clk) rda_in = 1'b0;
      rd(2'b01, d, a);
      checks++;
      if ({d, a} !== {8'h09, 1'b0}) begin errors++; $display("FAIL rx_status got=%h/%b exp=09/0", d, a); end
      rd(2'b00, d, a);
      checks++;
      if ({d, a} !== {8'h5A, 1'b1}) begin errors++; $display("FAIL rx_data got=%h/%b exp=5a/1", d, a); end
      rd(2'b01, d, a);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL rx_status2 got=%h exp=00", d); end
   endtask
   task automatic test_div_zero();
      logic [7:0] d;
      logic       a;
      int         bad = 0;
      wr(2'b10, 8'h00);
      wr(2'b11, 8'h00);
      wr(2'b11, 8'h00);
      rd(2'b10, d, a);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL zero_div_lo got=%h exp=00", d); end
      rd(2'b11, d, a);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL zero_div_hi got=%h exp=00", d); end
      for (int k = 0; k < 100; k++) begin
         if (rx_en || tx_en) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL zero_frozen got=%0d pulses exp=0", bad); end
      #3 rst = 1'b0;
      iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b10;
      #1 checks++;
      if (dout !== 8'h45) begin errors++; $display("FAIL zero_rst_lo got=%h exp=45", dout); end
      ioaddr = 2'b11;
      #1 checks++;
      if (dout !== 8'h01) begin errors++; $display("FAIL zero_rst_hi got=%h exp=01", dout); end
      iocs = 1'b0;
      @(negedge clk) rst = 1'b1;
   endtask
   task automatic test_reset_midtx();
      logic [7:0] d;
      logic       a;
      int         loads = 0;
      wr(2'b10, 8'h04);
      wr(2'b11, 8'h00);
      tbr_in = 1'b0;
      wr(2'b00, 8'h77);
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      #1 checks++;
      if ({tx_data, tx_load, rx_en, tx_en} !== 11'h0) begin
         errors++; $display("FAIL midtx_rst got=%h/%b%b%b exp=00/000", tx_data, tx_load, rx_en, tx_en);
      end
      @(negedge clk) rst = 1'b1;
      tbr_in = 1'b1;
      wr(2'b10, 8'h04);
      wr(2'b11, 8'h00);
      for (int k = 0; k < 150; k++) begin
         if (tx_load) loads++;
         @(negedge clk);
      end
      checks++;
      if (loads != 0) begin errors++; $display("FAIL midtx_loads got=%0d exp=0", loads); end
      rd(2'b01, d, a);
      checks++;
      if (d !== 8'h02) begin errors++; $display("FAIL midtx_status got=%h exp=02", d); end
   endtask
   initial begin
      test_reset();
      test_baud();
      test_tx();
      test_drop();
      test_rx();
      test_div_zero();
      test_reset_midtx();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
